// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage.
//   - ALUFunc encodings (MIPS funct field) used by the ALU and by the
//     accumulator-write decode.
//   - BrCode encodings (opcode[2:0]) selecting the branch/jump condition.
//   - outsel_t: source of the registered execute result.
//   - is_acc_func(): funct values that write the HI/LO accumulator.
package ex_pkg;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [2:0] BR_JR     = 3'b000;
  localparam logic [2:0] BR_REGIMM = 3'b001;
  localparam logic [2:0] BR_J      = 3'b010;
  localparam logic [2:0] BR_JAL    = 3'b011;
  localparam logic [2:0] BR_BEQ    = 3'b100;
  localparam logic [2:0] BR_BNE    = 3'b101;
  localparam logic [2:0] BR_BLEZ   = 3'b110;
  localparam logic [2:0] BR_BGTZ   = 3'b111;

  typedef enum logic [1:0] {
    ALU = 2'd0,
    BRA = 2'd1,
    MUL = 2'd2
  } outsel_t;

  function automatic logic is_acc_func(input logic [5:0] func);
    return (func == FN_MULT) || (func == FN_MULTU) ||
           (func == FN_MTHI) || (func == FN_MTLO);
  endfunction

endpackage

// File: rtl/ex_alu_branch_unit_if.sv
// ex_alu_branch_unit_if: bundle of decode-side inputs and registered
// execute outputs of the EX integer core.
//   slave  modport: the execute unit (reads decode fields, drives results).
//   master modport: the decode/stimulus side (drives fields, reads results).
interface ex_alu_branch_unit_if;

  logic        ALUOp;
  logic        MULOp;
  logic        Jump;
  logic        Branch;
  logic        ZeroB;
  logic        RegWriteIn;
  logic        MemWriteIn;
  logic        ALUSrc;
  logic        BRASrc;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Immediate;
  logic [31:0] PCin;
  logic [4:0]  Shamt;
  logic [5:0]  ALUFunc;
  logic [2:0]  BrCode;
  logic        BrRt;

  logic [31:0] Result;
  logic [3:0]  Flags;
  logic [31:0] PCout;
  logic        RegWriteOut;
  logic        BranchTaken;
  logic        ACCEn;

  modport master (
    output ALUOp, MULOp, Jump, Branch, ZeroB, RegWriteIn, MemWriteIn,
           ALUSrc, BRASrc, A, B, Immediate, PCin, Shamt, ALUFunc,
           BrCode, BrRt,
    input  Result, Flags, PCout, RegWriteOut, BranchTaken, ACCEn
  );

  modport slave (
    input  ALUOp, MULOp, Jump, Branch, ZeroB, RegWriteIn, MemWriteIn,
           ALUSrc, BRASrc, A, B, Immediate, PCin, Shamt, ALUFunc,
           BrCode, BrRt,
    output Result, Flags, PCout, RegWriteOut, BranchTaken, ACCEn
  );

endinterface

// File: rtl/ex_alu_branch_unit_alu.sv
// alu: combinational 32-bit integer ALU.
//   a_i      operand A
//   y_i      operand Y (already selected from B / Immediate / zero)
//   shamt_i  constant shift amount
//   func_i   MIPS funct encoding
//   res_o    result
//   flags_o  {C,Z,O,N}
import ex_pkg::*;

module alu (
  input  logic [31:0] a_i,
  input  logic [31:0] y_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  func_i,
  output logic [31:0] res_o,
  output logic [3:0]  flags_o
);

  logic [32:0] sum;
  logic [32:0] diff;
  logic [31:0] res;
  logic        carry;
  logic        ovf;

  // Both adder forms are always built; the carry of the subtract form
  // also serves SLT/SLTU, and SLTU's answer is simply "no carry".
  assign sum  = {1'b0, a_i} + {1'b0, y_i};
  assign diff = {1'b0, a_i} + {1'b0, ~y_i} + 33'd1;

  always_comb begin
    res   = 32'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (func_i)
      FN_SLL:  res = y_i << shamt_i;
      FN_SRL:  res = y_i >> shamt_i;
      FN_SRA:  res = $unsigned($signed(y_i) >>> shamt_i);
      FN_SLLV: res = y_i << a_i[4:0];
      FN_SRLV: res = y_i >> a_i[4:0];
      FN_SRAV: res = $unsigned($signed(y_i) >>> a_i[4:0]);
      FN_ADD, FN_ADDU: begin
        res   = sum[31:0];
        carry = sum[32];
        ovf   = (a_i[31] == y_i[31]) && (sum[31] != a_i[31]);
      end
      FN_SUB, FN_SUBU: begin
        res   = diff[31:0];
        carry = diff[32];
        ovf   = (a_i[31] != y_i[31]) && (diff[31] != a_i[31]);
      end
      FN_AND:  res = a_i & y_i;
      FN_OR:   res = a_i | y_i;
      FN_XOR:  res = a_i ^ y_i;
      FN_NOR:  res = ~(a_i | y_i);
      FN_SLT: begin
        res   = {31'd0, ($signed(a_i) < $signed(y_i))};
        carry = diff[32];
      end
      FN_SLTU: begin
        res   = {31'd0, ~diff[32]};
        carry = diff[32];
      end
      default: res = 32'd0;
    endcase
  end

  assign res_o   = res;
  assign flags_o = {carry, (res == 32'd0), ovf, res[31]};

endmodule

// File: rtl/ex_alu_branch_unit_branch.sv
// branch: combinational branch/jump resolution.
//   branch_i, jump_i  branch-class / jump-class instruction
//   br_code_i         opcode[2:0] condition select
//   br_rt_i           rt[0] for REGIMM (0 BLTZ, 1 BGEZ)
//   bra_src_i         1: target = Immediate, 0: target = A
//   flags_i           raw ALU flags {C,Z,O,N} of A-Y
//   a_i, imm_i, pc_i  register target, immediate target, PC+4
//   taken_o           redirect strobe
//   pc_o              redirect target, or PC+4 when not taken
//   ret_o             link value PC+8
import ex_pkg::*;

module branch (
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic [2:0]  br_code_i,
  input  logic        br_rt_i,
  input  logic        bra_src_i,
  input  logic [3:0]  flags_i,
  input  logic [31:0] a_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] pc_i,
  output logic        taken_o,
  output logic [31:0] pc_o,
  output logic [31:0] ret_o
);

  logic        zero;
  logic        less;
  logic        cond;
  logic [31:0] target;

  // Decode issues SUB for conditional branches, so N^O is signed A<Y.
  assign zero = flags_i[2];
  assign less = flags_i[0] ^ flags_i[1];

  always_comb begin
    cond = 1'b0;
    case (br_code_i)
      BR_BEQ:    cond = zero;
      BR_BNE:    cond = ~zero;
      BR_BLEZ:   cond = zero | less;
      BR_BGTZ:   cond = ~zero & ~less;
      BR_REGIMM: cond = br_rt_i ? ~less : less;
      BR_JR, BR_J, BR_JAL: cond = jump_i;
      default:   cond = 1'b0;
    endcase
  end

  assign taken_o = (branch_i | jump_i) & cond;
  assign target  = bra_src_i ? imm_i : a_i;
  assign pc_o    = taken_o ? target : pc_i;
  // PCin already points past the branch; the link skips the delay slot.
  assign ret_o   = pc_i + 32'd4;

endmodule

// File: rtl/ex_alu_branch_unit_ex_control.sv
// ex_control: result/flag selection and writeback control.
//   mul_op_i, jump_i           instruction class
//   reg_write_i, mem_write_i   decode writeback / store request
//   alu_func_i                 funct field, for accumulator-write decode
//   alu_res_i, alu_flags_i     ALU outputs
//   ret_i                      link value
//   outsel_o                   selected result source
//   result_o, flags_o          selected result and flags
//   reg_write_o, acc_en_o      register-file and HI/LO write enables
import ex_pkg::*;

module ex_control (
  input  logic        mul_op_i,
  input  logic        jump_i,
  input  logic        reg_write_i,
  input  logic        mem_write_i,
  input  logic [5:0]  alu_func_i,
  input  logic [31:0] alu_res_i,
  input  logic [3:0]  alu_flags_i,
  input  logic [31:0] ret_i,
  output outsel_t     outsel_o,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o,
  output logic        reg_write_o,
  output logic        acc_en_o
);

  outsel_t outsel;

  // MULOp outranks Jump here; the redirect of a jump is resolved
  // independently, so it still happens with a multiply-class result.
  assign outsel = mul_op_i ? MUL : (jump_i ? BRA : ALU);

  always_comb begin
    result_o = 32'd0;
    flags_o  = 4'd0;
    case (outsel)
      ALU: begin
        result_o = alu_res_i;
        flags_o  = alu_flags_i;
      end
      BRA:     result_o = ret_i;
      MUL:     result_o = 32'd0;
      default: result_o = 32'd0;
    endcase
  end

  assign acc_en_o    = mul_op_i & is_acc_func(alu_func_i);
  assign reg_write_o = reg_write_i & ~mem_write_i & ~acc_en_o;
  assign outsel_o    = outsel;

endmodule

// File: rtl/ex_alu_branch_unit.sv
// ex_alu_branch_unit: execute-stage integer core (ALU, branch resolution,
// execute control) with one output register stage.
//   Clock   rising-edge clock
//   nReset  asynchronous active-low reset; clears all outputs at once
//   bus     slave side of ex_alu_branch_unit_if: decode fields in,
//           Result/Flags/PCout/RegWriteOut/BranchTaken/ACCEn out
// A new operation is accepted every cycle; outputs follow one cycle later.
import ex_pkg::*;

module ex_alu_branch_unit (
  input  logic                 Clock,
  input  logic                 nReset,
  ex_alu_branch_unit_if.slave  bus
);

  logic [31:0] y_op;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic        taken_d;
  logic [31:0] pc_d;
  logic [31:0] ret;
  outsel_t     outsel;
  logic [31:0] result_d;
  logic [3:0]  flags_d;
  logic        reg_write_d;
  logic        acc_en_d;

  logic [31:0] result_q;
  logic [3:0]  flags_q;
  logic [31:0] pc_q;
  logic        reg_write_q;
  logic        taken_q;
  logic        acc_en_q;

  // ALUOp adds nothing beyond ALUFunc/Jump/MULOp: ALU-class and branch
  // ops both take the ALU path, and the redirect depends only on
  // Branch/Jump, so a set Branch is never masked by ALUOp.
  logic unused_aluop;
  logic unused_outsel;
  assign unused_aluop  = bus.ALUOp;
  assign unused_outsel = ^outsel;

  // Compare-with-zero branches force Y to 0 even if ALUSrc is set.
  assign y_op = bus.ZeroB ? 32'd0 : (bus.ALUSrc ? bus.Immediate : bus.B);

  alu u_alu (
    .a_i     (bus.A),
    .y_i     (y_op),
    .shamt_i (bus.Shamt),
    .func_i  (bus.ALUFunc),
    .res_o   (alu_res),
    .flags_o (alu_flags)
  );

  branch u_branch (
    .branch_i  (bus.Branch),
    .jump_i    (bus.Jump),
    .br_code_i (bus.BrCode),
    .br_rt_i   (bus.BrRt),
    .bra_src_i (bus.BRASrc),
    .flags_i   (alu_flags),
    .a_i       (bus.A),
    .imm_i     (bus.Immediate),
    .pc_i      (bus.PCin),
    .taken_o   (taken_d),
    .pc_o      (pc_d),
    .ret_o     (ret)
  );

  ex_control u_ex_control (
    .mul_op_i    (bus.MULOp),
    .jump_i      (bus.Jump),
    .reg_write_i (bus.RegWriteIn),
    .mem_write_i (bus.MemWriteIn),
    .alu_func_i  (bus.ALUFunc),
    .alu_res_i   (alu_res),
    .alu_flags_i (alu_flags),
    .ret_i       (ret),
    .outsel_o    (outsel),
    .result_o    (result_d),
    .flags_o     (flags_d),
    .reg_write_o (reg_write_d),
    .acc_en_o    (acc_en_d)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      result_q    <= 32'd0;
      flags_q     <= 4'd0;
      pc_q        <= 32'd0;
      reg_write_q <= 1'b0;
      taken_q     <= 1'b0;
      acc_en_q    <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      pc_q        <= pc_d;
      reg_write_q <= reg_write_d;
      taken_q     <= taken_d;
      acc_en_q    <= acc_en_d;
    end
  end

  assign bus.Result      = result_q;
  assign bus.Flags       = flags_q;
  assign bus.PCout       = pc_q;
  assign bus.RegWriteOut = reg_write_q;
  assign bus.BranchTaken = taken_q;
  assign bus.ACCEn       = acc_en_q;

endmodule

// File: tb/tb_ex_alu_branch_unit.sv
// tb_ex_alu_branch_unit: directed vectors with hand-computed expectations
// for the execute-stage core. Inputs change on the falling edge, outputs
// are sampled on the following falling edge. Flags are {C,Z,O,N}.
module tb_ex_alu_branch_unit;

  logic Clock;
  logic nReset;
  int   checks;
  int   errors;

  ex_alu_branch_unit_if bus ();

  ex_alu_branch_unit dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input logic [3:0] flg,
                            input logic [31:0] pc, input logic rw, input logic bt,
                            input logic acc);
    check({tag, ".Result"},      bus.Result,             res);
    check({tag, ".Flags"},       {28'd0, bus.Flags},     {28'd0, flg});
    check({tag, ".PCout"},       bus.PCout,              pc);
    check({tag, ".RegWriteOut"}, {31'd0, bus.RegWriteOut}, {31'd0, rw});
    check({tag, ".BranchTaken"}, {31'd0, bus.BranchTaken}, {31'd0, bt});
    check({tag, ".ACCEn"},       {31'd0, bus.ACCEn},     {31'd0, acc});
    $display("op %-10s Result=%08h Flags=%04b PCout=%08h RW=%0b BT=%0b ACC=%0b",
             tag, bus.Result, bus.Flags, bus.PCout, bus.RegWriteOut,
             bus.BranchTaken, bus.ACCEn);
  endtask

  task automatic clear_inputs();
    bus.ALUOp = 0; bus.MULOp = 0; bus.Jump = 0; bus.Branch = 0;
    bus.ZeroB = 0; bus.RegWriteIn = 0; bus.MemWriteIn = 0;
    bus.ALUSrc = 0; bus.BRASrc = 0;
    bus.A = 0; bus.B = 0; bus.Immediate = 0; bus.PCin = 0;
    bus.Shamt = 0; bus.ALUFunc = 0; bus.BrCode = 0; bus.BrRt = 0;
  endtask

  task automatic alu_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc);
    clear_inputs();
    bus.ALUOp = 1; bus.RegWriteIn = 1; bus.ALUFunc = fn;
    bus.A = a; bus.B = b; bus.PCin = pc;
  endtask

  task automatic br_op(input logic [2:0] code, input logic rt, input logic zb,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc);
    clear_inputs();
    bus.Branch = 1; bus.ALUFunc = 6'b100010; bus.BRASrc = 1;
    bus.BrCode = code; bus.BrRt = rt; bus.ZeroB = zb;
    bus.A = a; bus.B = b; bus.Immediate = imm; bus.PCin = pc;
  endtask

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    nReset = 1'b0;
    #1;
    expect_out("reset", 32'h0, 4'b0000, 32'h0, 0, 0, 0);

    @(negedge Clock);
    nReset = 1'b1;

    // ADD signed overflow
    alu_op(6'b100000, 32'h7FFFFFFF, 32'h1, 32'h00000104);
    step();
    expect_out("add_ovf", 32'h80000000, 4'b0011, 32'h00000104, 1, 0, 0);

    // SUB signed overflow, borrow-free carry
    alu_op(6'b100010, 32'h80000000, 32'h1, 32'h00000108);
    step();
    expect_out("sub_ovf", 32'h7FFFFFFF, 4'b1010, 32'h00000108, 1, 0, 0);

    // BEQ 5==5 taken to immediate
    br_op(3'b100, 0, 0, 32'h5, 32'h5, 32'h00400020, 32'h00400004);
    step();
    expect_out("beq", 32'h0, 4'b1100, 32'h00400020, 0, 1, 0);

    // BNE 5==5 not taken
    br_op(3'b101, 0, 0, 32'h5, 32'h5, 32'h00400020, 32'h00400008);
    step();
    expect_out("bne", 32'h0, 4'b1100, 32'h00400008, 0, 0, 0);

    // BGTZ -1 not taken; ZeroB wins over ALUSrc
    br_op(3'b111, 0, 1, 32'hFFFFFFFF, 32'h12345678, 32'h00400300, 32'h00400104);
    bus.ALUSrc = 1;
    step();
    expect_out("bgtz", 32'hFFFFFFFF, 4'b1001, 32'h00400104, 0, 0, 0);

    // BLTZ -1 taken
    br_op(3'b001, 0, 1, 32'hFFFFFFFF, 32'h0, 32'h00400200, 32'h00400108);
    step();
    expect_out("bltz", 32'hFFFFFFFF, 4'b1001, 32'h00400200, 0, 1, 0);

    // BGEZ 0 taken
    br_op(3'b001, 1, 1, 32'h0, 32'h0, 32'h00400400, 32'h0040010C);
    step();
    expect_out("bgez", 32'h0, 4'b1100, 32'h00400400, 0, 1, 0);

    // BLEZ 1 not taken
    br_op(3'b110, 0, 1, 32'h1, 32'h0, 32'h00400500, 32'h00400110);
    step();
    expect_out("blez", 32'h1, 4'b1000, 32'h00400110, 0, 0, 0);

    // JAL: link PC+8, redirect to immediate
    clear_inputs();
    bus.Jump = 1; bus.BrCode = 3'b011; bus.BRASrc = 1; bus.RegWriteIn = 1;
    bus.Immediate = 32'h00003000; bus.PCin = 32'h00001004;
    step();
    expect_out("jal", 32'h00001008, 4'b0000, 32'h00003000, 1, 1, 0);

    // JR: register target
    clear_inputs();
    bus.Jump = 1; bus.BrCode = 3'b000; bus.BRASrc = 0;
    bus.A = 32'h00002000; bus.PCin = 32'h00001010;
    step();
    expect_out("jr", 32'h00001014, 4'b0000, 32'h00002000, 0, 1, 0);

    // JALR with link wrap-around
    clear_inputs();
    bus.Jump = 1; bus.BrCode = 3'b000; bus.RegWriteIn = 1;
    bus.A = 32'h00000040; bus.PCin = 32'hFFFFFFFC;
    step();
    expect_out("jalr_wrap", 32'h00000000, 4'b0000, 32'h00000040, 1, 1, 0);

    // SRAV by A[4:0]=4 of Y=F0000000
    alu_op(6'b000111, 32'h4, 32'hF0000000, 32'h0000020C);
    step();
    expect_out("srav", 32'hFF000000, 4'b0001, 32'h0000020C, 1, 0, 0);

    // SLL by Shamt
    alu_op(6'b000000, 32'h0, 32'h00000003, 32'h00000210);
    bus.Shamt = 5'd4;
    step();
    expect_out("sll", 32'h00000030, 4'b0000, 32'h00000210, 1, 0, 0);

    // SLTU 1 < FFFFFFFF
    alu_op(6'b101011, 32'h1, 32'hFFFFFFFF, 32'h00000214);
    step();
    expect_out("sltu", 32'h1, 4'b0000, 32'h00000214, 1, 0, 0);

    // SLT 1 < -1 is false
    alu_op(6'b101010, 32'h1, 32'hFFFFFFFF, 32'h00000218);
    step();
    expect_out("slt", 32'h0, 4'b0100, 32'h00000218, 1, 0, 0);

    // NOR
    alu_op(6'b100111, 32'h0F0F0000, 32'h000000F0, 32'h0000021C);
    step();
    expect_out("nor", 32'hF0F0FF0F, 4'b0001, 32'h0000021C, 1, 0, 0);

    // Undefined funct -> 0, Z set
    alu_op(6'b001000, 32'h12345678, 32'h1, 32'h00000220);
    step();
    expect_out("undef", 32'h0, 4'b0100, 32'h00000220, 1, 0, 0);

    // Store address: immediate operand, no writeback
    alu_op(6'b100001, 32'h00000100, 32'hDEADBEEF, 32'h00000224);
    bus.MemWriteIn = 1; bus.ALUSrc = 1; bus.Immediate = 32'h8;
    step();
    expect_out("store", 32'h00000108, 4'b0000, 32'h00000224, 0, 0, 0);

    // MULT: accumulator write, no register writeback, zero result
    clear_inputs();
    bus.MULOp = 1; bus.ALUFunc = 6'b011000; bus.RegWriteIn = 1;
    bus.A = 32'h3; bus.B = 32'h5; bus.PCin = 32'h00000228;
    step();
    expect_out("mult", 32'h0, 4'b0000, 32'h00000228, 0, 0, 1);

    // MFHI-style multiply op: no accumulator write, writeback kept
    clear_inputs();
    bus.MULOp = 1; bus.ALUFunc = 6'b010000; bus.RegWriteIn = 1;
    bus.PCin = 32'h0000022C;
    step();
    expect_out("mfhi", 32'h0, 4'b0000, 32'h0000022C, 1, 0, 0);

    // Reset mid-cycle with a live op: outputs drop at once
    alu_op(6'b100000, 32'h7FFFFFFF, 32'h1, 32'h00000300);
    @(posedge Clock);
    #2;
    check("pre_reset.Result", bus.Result, 32'h80000000);
    nReset = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 4'b0000, 32'h0, 0, 0, 0);
    step();
    expect_out("rst_held", 32'h0, 4'b0000, 32'h0, 0, 0, 0);
    nReset = 1'b1;
    step();
    expect_out("post_rst", 32'h80000000, 4'b0011, 32'h00000300, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
